// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart_tx message arbiter.
//   arb_state_t : arbiter FSM state (IDLE, BUSY)
//   id_width(n) : index width for n items, never less than 1
package uart_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   function automatic int unsigned id_width(input int unsigned n);
      return (n <= 2) ? 1 : int'($clog2(n));
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
//   req  in   N   request vector
//   ptr  in   IW  search start index
//   any  out  1   at least one request set
//   idx  out  IW  chosen index (0 when none)
module rr_pick
   import uart_arb_pkg::*;
#(
   parameter int unsigned N = 4,
   localparam int unsigned IW = id_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          any,
   output logic [IW-1:0] idx
);

   logic [N-1:0]   mask;
   logic [2*N-1:0] dbl;

   // Lower copy keeps only requests at/after ptr; upper copy supplies the wrapped ones.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         mask[i] = (i >= int'(ptr));
      end
      dbl = {req, req & mask};
      any = |req;
      idx = '0;
      // Descending scan so the lowest set position of the doubled vector wins.
      for (int i = 2*N-1; i >= 0; i--) begin
         if (dbl[i]) begin
            idx = (i >= int'(N)) ? IW'(i - int'(N)) : IW'(i);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one uart_tx byte sink.
//   clk, rst          clock, synchronous active-high reset
//   req_data/valid/last/ready   per-requester byte stream (byte i at [i*8+:8])
//   byte_out_data/valid/ready   handshake toward uart_tx byte_in_*
//   grant_valid/grant_id        current sink owner
//   abort_pulse/abort_id        watchdog release of a stalled owner
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 0,
   localparam int unsigned IDW  = id_width(NUM_REQ),
   localparam int unsigned CNTW = id_width(TIMEOUT_CYCLES + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ*8-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           byte_out_data,
   output logic                 byte_out_valid,
   input  logic                 byte_out_ready,
   output logic                 grant_valid,
   output logic [IDW-1:0]       grant_id,
   output logic                 abort_pulse,
   output logic [IDW-1:0]       abort_id
);

   arb_state_t      state, state_nxt;
   logic [IDW-1:0]  ptr, ptr_nxt;
   logic [IDW-1:0]  gid_nxt, abort_id_nxt;
   logic            gv_nxt, abort_nxt;
   logic [CNTW-1:0] wd_cnt, wd_cnt_nxt;

   logic            pick_any;
   logic [IDW-1:0]  pick_idx;
   logic            g_valid, g_last, beat, timeout;
   logic [7:0]      g_data;

   function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] g);
      return (g == IDW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
   endfunction

   rr_pick #(.N(NUM_REQ)) u_pick (
      .req (req_valid),
      .ptr (ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   // Owner's stream, selected by the registered grant.
   assign g_valid = req_valid[grant_id];
   assign g_last  = req_last[grant_id];
   assign g_data  = req_data[32'(grant_id)*8 +: 8];
   assign beat    = g_valid & byte_out_ready;
   assign timeout = (TIMEOUT_CYCLES != 0) && !g_valid
                    && (wd_cnt == CNTW'(TIMEOUT_CYCLES - 1));

   // State, grant, pointer and watchdog registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= '0;
         wd_cnt      <= '0;
         grant_valid <= 1'b0;
         grant_id    <= '0;
         abort_pulse <= 1'b0;
         abort_id    <= '0;
      end else begin
         state       <= state_nxt;
         ptr         <= ptr_nxt;
         wd_cnt      <= wd_cnt_nxt;
         grant_valid <= gv_nxt;
         grant_id    <= gid_nxt;
         abort_pulse <= abort_nxt;
         abort_id    <= abort_id_nxt;
      end
   end

   // Next-state logic and sink pass-through.
   always_comb begin
      state_nxt      = state;
      ptr_nxt        = ptr;
      wd_cnt_nxt     = '0;
      gv_nxt         = grant_valid;
      gid_nxt        = grant_id;
      abort_nxt      = 1'b0;
      abort_id_nxt   = abort_id;
      req_ready      = '0;
      byte_out_data  = 8'h00;
      byte_out_valid = 1'b0;

      case (state)
         IDLE: begin
            if (pick_any) begin
               state_nxt = BUSY;
               gv_nxt    = 1'b1;
               gid_nxt   = pick_idx;
            end
         end
         BUSY: begin
            byte_out_data       = g_data;
            byte_out_valid      = g_valid;
            req_ready[grant_id] = byte_out_ready;
            if (beat && g_last) begin
               state_nxt = IDLE;
               gv_nxt    = 1'b0;
               ptr_nxt   = next_id(grant_id);
            end else if (timeout) begin
               // Owner went quiet mid-message: free the sink and flag it.
               state_nxt    = IDLE;
               gv_nxt       = 1'b0;
               ptr_nxt      = next_id(grant_id);
               abort_nxt    = 1'b1;
               abort_id_nxt = grant_id;
            end else if (!g_valid && TIMEOUT_CYCLES != 0) begin
               wd_cnt_nxt = wd_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=5) with a
// behavioural uart_tx sink that is busy for 10 bits x 4 clocks after each byte.
module tb_uart_tx_arbiter;

   localparam int unsigned NR        = 4;
   localparam int          SINK_BUSY = 40;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NR*8-1:0] req_data = '0;
   logic [NR-1:0]   req_valid = '0;
   logic [NR-1:0]   req_last = '0;
   logic [NR-1:0]   req_ready;
   logic [7:0]      byte_out_data;
   logic            byte_out_valid;
   logic            byte_out_ready = 1'b0;
   logic            grant_valid;
   logic [1:0]      grant_id;
   logic            abort_pulse;
   logic [1:0]      abort_id;

   uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(5)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_data       (req_data),
      .req_valid      (req_valid),
      .req_last       (req_last),
      .req_ready      (req_ready),
      .byte_out_data  (byte_out_data),
      .byte_out_valid (byte_out_valid),
      .byte_out_ready (byte_out_ready),
      .grant_valid    (grant_valid),
      .grant_id       (grant_id),
      .abort_pulse    (abort_pulse),
      .abort_id       (abort_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         pre;     // requester that completes a 1-byte message first (-1: none)
      logic [3:0] mask;    // req_valid presented in IDLE
      logic       rdy;     // byte_out_ready level
      int         exp_id;  // expected grant
   } vec_t;

   vec_t tbl [10];

   int checks = 0;
   int passed = 0;
   int cyc    = 0;

   // Producer byte stores: {last, data}, head/tail per requester.
   logic [8:0] pmem [NR][16];
   int         ph [NR];
   int         pt [NR];

   int   exp_q [$];   // bytes the sink must receive, in order
   int   exp_g [$];   // grant owners expected, in order
   bit   prod_en, sink_en, ready_man, pend_last, gv_prev, gap_chk;
   int   busy;
   int   last_fall_cyc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic drive_prod();
      for (int i = 0; i < NR; i++) begin
         if (ph[i] < pt[i]) begin
            req_valid[i]       = 1'b1;
            req_data[i*8 +: 8] = pmem[i][ph[i]][7:0];
            req_last[i]        = pmem[i][ph[i]][8];
         end else begin
            req_valid[i]       = 1'b0;
            req_data[i*8 +: 8] = 8'h00;
            req_last[i]        = 1'b0;
         end
      end
   endtask

   task automatic push_raw(input int id, input logic [7:0] d, input logic l);
      pmem[id][pt[id]] = {l, d};
      pt[id]++;
   endtask

   task automatic push_msg(input int id, input int n, input logic [7:0] base);
      for (int k = 0; k < n; k++) push_raw(id, base + 8'(k), k == n - 1);
   endtask

   task automatic expect_bytes(input logic [7:0] base, input int n);
      for (int k = 0; k < n; k++) exp_q.push_back(int'(base) + k);
   endtask

   // Sampling-point observations shared by every phase.
   task automatic observe();
      logic [NR-1:0] owner;
      bit rise, fall;
      owner = grant_valid ? (NR'(1) << grant_id) : '0;
      chk("nonowner_ready", 32'(req_ready & ~owner), 32'd0);
      if (pend_last) chk("release_after_last", 32'(grant_valid), 32'd0);
      pend_last = byte_out_valid && byte_out_ready && grant_valid && req_last[grant_id];
      rise = grant_valid && !gv_prev;
      fall = !grant_valid && gv_prev;
      gv_prev = grant_valid;
      if (sink_en && byte_out_valid && byte_out_ready) begin
         if (exp_q.size() == 0) chk("unexpected_byte", 32'(byte_out_data), 32'hFFFF);
         else chk("byte_order", 32'(byte_out_data), 32'(exp_q.pop_front()));
      end
      if (rise && sink_en) begin
         if (exp_g.size() == 0) chk("unexpected_grant", 32'(grant_id), 32'hFFFF);
         else chk("grant_order", 32'(grant_id), 32'(exp_g.pop_front()));
         if (gap_chk && last_fall_cyc >= 0) chk("idle_gap", 32'(cyc - last_fall_cyc), 32'd1);
      end
      if (fall) last_fall_cyc = cyc;
   endtask

   // One clock: retire accepted bytes, update sink, redrive, then sample mid-cycle.
   task automatic tick();
      logic [NR-1:0] acc;
      bit cap;
      acc = req_valid & req_ready;
      cap = sink_en && byte_out_valid && byte_out_ready;
      @(posedge clk);
      #1;
      if (prod_en) begin
         for (int i = 0; i < NR; i++) if (acc[i] && ph[i] < pt[i]) ph[i]++;
      end
      if (sink_en) begin
         if (cap) busy = SINK_BUSY;
         else if (busy > 0) busy--;
         byte_out_ready = (busy == 0);
      end else begin
         byte_out_ready = ready_man;
      end
      if (prod_en) drive_prod();
      #4;
      cyc++;
      observe();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      prod_en = 0; sink_en = 0; ready_man = 0; gap_chk = 0;
      req_valid = '0; req_last = '0; req_data = '0;
      for (int i = 0; i < NR; i++) begin ph[i] = 0; pt[i] = 0; end
      busy = 0; pend_last = 0;
      exp_q.delete(); exp_g.delete();
      last_fall_cyc = -1;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic start_seq();
      prod_en = 1; sink_en = 1;
      byte_out_ready = (busy == 0);
   endtask

   function automatic bit prod_pending();
      for (int i = 0; i < NR; i++) if (ph[i] < pt[i]) return 1;
      return 0;
   endfunction

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while ((prod_pending() || exp_q.size() != 0 || exp_g.size() != 0 || grant_valid)
             && n < budget) begin
         tick(); n++;
      end
      chk({name, "_drained"}, 32'(n < budget), 32'd1);
   endtask

   initial begin
      int n, cap_c, ab_c;
      logic [NR-1:0] exp_rdy;

      tbl[0] = '{-1, 4'b0001, 1'b1, 0};
      tbl[1] = '{-1, 4'b1010, 1'b1, 1};
      tbl[2] = '{-1, 4'b1000, 1'b0, 3};
      tbl[3] = '{ 0, 4'b1111, 1'b1, 1};
      tbl[4] = '{ 1, 4'b0011, 1'b1, 0};
      tbl[5] = '{ 2, 4'b0101, 1'b1, 0};
      tbl[6] = '{ 3, 4'b1100, 1'b1, 2};
      tbl[7] = '{ 1, 4'b1100, 1'b0, 2};
      tbl[8] = '{ 2, 4'b1010, 1'b1, 3};
      tbl[9] = '{ 0, 4'b0001, 1'b1, 0};

      // Reset state.
      do_reset();
      chk("rst_grant_valid", 32'(grant_valid), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_out_valid", 32'(byte_out_valid), 32'd0);
      chk("rst_out_data", 32'(byte_out_data), 32'd0);
      chk("rst_abort_pulse", 32'(abort_pulse), 32'd0);
      chk("rst_abort_id", 32'(abort_id), 32'd0);

      // Arbitration vectors: optional pointer setup, then one IDLE pick.
      for (int e = 0; e < 10; e++) begin
         do_reset();
         if (tbl[e].pre >= 0) begin
            req_valid = NR'(1) << tbl[e].pre;
            req_last  = '1;
            req_data  = {NR{8'hA0}};
            ready_man = 1'b1;
            byte_out_ready = 1'b1;
            tick(); tick();
            chk("vec_pre_release", 32'(grant_valid), 32'd0);
         end
         req_last  = '0;
         req_valid = tbl[e].mask;
         for (int i = 0; i < NR; i++) req_data[i*8 +: 8] = 8'(16 * i + e);
         ready_man = tbl[e].rdy;
         byte_out_ready = ready_man;
         #1;
         chk("vec_idle_no_ready", 32'(req_ready), 32'd0);
         chk("vec_idle_no_valid", 32'(byte_out_valid), 32'd0);
         tick();
         exp_rdy = tbl[e].rdy ? (NR'(1) << tbl[e].exp_id) : '0;
         chk("vec_grant_valid", 32'(grant_valid), 32'd1);
         chk("vec_grant_id", 32'(grant_id), 32'(tbl[e].exp_id));
         chk("vec_req_ready", 32'(req_ready), 32'(exp_rdy));
         chk("vec_out_valid", 32'(byte_out_valid), 32'd1);
         chk("vec_out_data", 32'(byte_out_data), 32'(16 * tbl[e].exp_id + e));
      end

      // A: lone 3-byte message from req0.
      do_reset(); start_seq();
      push_raw(0, 8'h11, 1'b0); push_raw(0, 8'h22, 1'b0); push_raw(0, 8'h33, 1'b1);
      expect_bytes(8'h11, 1); expect_bytes(8'h22, 1); expect_bytes(8'h33, 1);
      exp_g.push_back(0);
      drive_prod();
      #1;
      chk("A_no_grant_yet", 32'(grant_valid), 32'd0);
      tick();
      chk("A_grant_valid", 32'(grant_valid), 32'd1);
      chk("A_grant_id", 32'(grant_id), 32'd0);
      wait_drain("A", 2000);

      // B: all four requesters, 2-byte messages, from reset.
      do_reset(); start_seq();
      for (int i = 0; i < NR; i++) begin
         push_msg(i, 2, 8'(8'h40 + 16 * i));
         expect_bytes(8'(8'h40 + 16 * i), 2);
         exp_g.push_back(i);
      end
      drive_prod();
      wait_drain("B", 2000);

      // C: req1 arrives while req2 is mid-message.
      do_reset(); start_seq();
      push_msg(2, 3, 8'h20); expect_bytes(8'h20, 3); exp_g.push_back(2);
      drive_prod();
      n = 0;
      while (exp_q.size() != 2 && n < 200) begin tick(); n++; end
      chk("C_first_byte", 32'(n < 200), 32'd1);
      push_msg(1, 2, 8'h10); expect_bytes(8'h10, 2); exp_g.push_back(1);
      drive_prod();
      #1;
      chk("C_req1_stalled", 32'(req_ready[1]), 32'd0);
      chk("C_owner_still_2", 32'(grant_id), 32'd2);
      wait_drain("C", 2000);

      // D: req1 stalls after one non-last byte; watchdog hands over to req3.
      do_reset(); start_seq();
      push_raw(1, 8'h5A, 1'b0); expect_bytes(8'h5A, 1); exp_g.push_back(1);
      drive_prod();
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
      chk("D_byte_taken", 32'(n < 200), 32'd1);
      cap_c = cyc;
      push_raw(3, 8'h3C, 1'b1); expect_bytes(8'h3C, 1); exp_g.push_back(3);
      drive_prod();
      n = 0;
      while (!abort_pulse && n < 20) begin tick(); n++; end
      ab_c = cyc;
      chk("D_abort_seen", 32'(abort_pulse), 32'd1);
      // Valid drops in cycle cap_c+1; abort fires 5 cycles after that.
      chk("D_abort_delay", 32'(ab_c - cap_c), 32'd6);
      chk("D_abort_id", 32'(abort_id), 32'd1);
      chk("D_abort_released", 32'(grant_valid), 32'd0);
      tick();
      chk("D_pulse_one_cycle", 32'(abort_pulse), 32'd0);
      chk("D_abort_id_held", 32'(abort_id), 32'd1);
      chk("D_next_grant_valid", 32'(grant_valid), 32'd1);
      chk("D_next_grant_id", 32'(grant_id), 32'd3);
      wait_drain("D", 2000);

      // E: reset lands on a BUSY beat of req2.
      do_reset(); start_seq();
      push_msg(2, 3, 8'h70); expect_bytes(8'h70, 1); exp_g.push_back(2);
      drive_prod();
      tick();
      chk("E_beat_in_progress", 32'(byte_out_valid & byte_out_ready), 32'd1);
      push_msg(1, 2, 8'h60); push_msg(3, 2, 8'h80);
      expect_bytes(8'h60, 2); expect_bytes(8'h71, 2); expect_bytes(8'h80, 2);
      exp_g.push_back(1); exp_g.push_back(2); exp_g.push_back(3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("E_grant_dropped", 32'(grant_valid), 32'd0);
      chk("E_ready_zero", 32'(req_ready), 32'd0);
      tick();
      chk("E_lowest_after_rst", 32'(grant_id), 32'd1);
      wait_drain("E", 3000);

      // F: back-to-back single-byte messages from req0 only.
      do_reset(); start_seq();
      gap_chk = 1;
      for (int k = 0; k < 4; k++) begin
         push_raw(0, 8'(8'h90 + k), 1'b1);
         exp_g.push_back(0);
      end
      expect_bytes(8'h90, 4);
      drive_prod();
      wait_drain("F", 2000);
      gap_chk = 0;

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
